key_scan: RTL and testbench
===========================

// Module: key_scan
// PURPOSE
//  Scans a 4x4 matrix keypad: drives columns active-low one at a time, reads active-low rows.
//  Debounces the result and reports one code per press, plus a held-level flag.
//  It is the input-side companion of the multiplexed 7-seg driver on the same board.
//  It advances on the same shared ENABLE scan tick.
// PARAMETERS
//  SETTLE   2  ENABLE ticks each column is driven before its rows are sampled (>=1)
//  DEB_CNT  4  consecutive identical scan frames needed to accept a press or release (>=1)
// PORTS
//  CLK     in   1  system clock, rising edge
//  RST     in   1  asynchronous reset, active-high
//  ENABLE  in   1  scan tick, 1-cycle pulse; all counters hold while low
//  ROW     in   4  keypad rows, active-low, asynchronous to CLK
//  COL     out  4  column strobes, active-low, exactly one bit low
//  KEY     out  4  code of last accepted key = col*4 + row
//  VALID   out  1  1-cycle pulse when a debounced press is accepted
//  HELD    out  1  high from acceptance until debounced release
// BEHAVIOUR
//  Reset (async, immediate): col=0, COL=4'b1110, settle cnt=0, frame cleared, state IDLE,
//   KEY=0, VALID=0, HELD=0; ROW synchroniser flops reset to 4'b1111.
//  ROW passes a 2-flop synchroniser; all decisions use the synchronised value.
//  Scan: on ENABLE, settle cnt++; at ENABLE with cnt==SETTLE-1, sample synced ROW for the
//   current column, cnt<=0, col<=col+1 mod 4 (3->0 wraps); COL = ~(1<<col).
//  Frame = 4 column samples (col 0..3); frame period = 4*SETTLE ENABLE ticks.
//  Frame result: NONE (no low row bit), SINGLE(code) (exactly one low bit in frame),
//   MULTI (>=2 low bits anywhere in frame; ghosting, treated as invalid).
//  FSM evaluates once per frame, in the cycle after the ENABLE that sampled column 3:
//   IDLE:     SINGLE(c) -> PRESS_CHK, cand=c, dcnt=1 (DEB_CNT==1: straight to accept).
//             NONE/MULTI -> stay.
//   PRESS_CHK: SINGLE(cand) -> dcnt++; when dcnt reaches DEB_CNT -> HELD, KEY<=cand,
//              VALID=1 for one cycle. SINGLE(other)/NONE/MULTI -> IDLE, dcnt=0.
//   HELD:     NONE -> REL_CHK, dcnt=1. SINGLE(any)/MULTI -> stay HELD.
//             A second key needs a full release first.
//   REL_CHK:  NONE -> dcnt++; at DEB_CNT -> IDLE, HELD<=0.
//             SINGLE/MULTI -> back to HELD, no VALID.
//  HELD output = 1 in states HELD and REL_CHK. KEY holds its value until the next accept.
//  Latency: press stable from a frame start -> VALID at the end of frame DEB_CNT,
//   plus the synchroniser delay of 2 CLK.
//  ENABLE low mid-frame: scan, frame and FSM freeze; nothing is lost or duplicated.
//  Counters: settle cnt is clog2(SETTLE) bits, dcnt is clog2(DEB_CNT+1) bits; no overflow past the limit.
// TESTING (SETTLE=2, DEB_CNT=4, ENABLE high every cycle unless stated)
//  1 Reset, ROW=1111 -> COL=1110, KEY=0, VALID=0, HELD=0; COL steps 1110,1101,1011,0111,1110,
//    2 ticks each.
//  2 Key row2/col1 (ROW[2]=0 while COL[1]=0) held -> one VALID pulse after frame 4,
//    KEY=6, HELD=1; no further VALID while held.
//  3 Key row2/col1 present for 3 frames, then 1 empty frame -> no VALID, FSM back to IDLE, HELD=0.
//  4 Keys row0/col0 and row3/col2 both held -> MULTI each frame -> no VALID, KEY unchanged.
//  5 After test 2: 2 empty frames, key again, 4 empty frames -> HELD stays 1 and no VALID
//    until the final 4 empty frames, then HELD=0.
//  6 RST pulse while in PRESS_CHK (dcnt=3), key still pressed -> outputs reset at once.
//    After release of RST, VALID comes only after 4 new full frames. Repeat with ENABLE
//    toggled 1-of-3 cycles -> same VALID count, timing stretched 3x.

Source files
------------

// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: walks active-low column strobes on the shared ENABLE tick,
// synchronises the active-low rows, debounces whole scan frames and reports one code per press.
module key_scan #(
    parameter int SETTLE  = 2,
    parameter int DEB_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       valid,
    output logic       held
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int DW = $clog2(DEB_CNT + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_CHK = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_CHK   = 2'd3
    } state_t;

    function automatic logic [2:0] low_count(input logic [3:0] r);
        low_count = 3'd0;
        for (int i = 0; i < 4; i++) begin
            low_count = low_count + {2'd0, ~r[i]};
        end
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] r);
        low_index = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r[i]) begin
                low_index = 2'(i);
            end
        end
    endfunction

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [1:0]    col_idx;
    logic [SW-1:0] settle_cnt;
    logic          s1_vld;
    logic [1:0]    s1_col;
    logic          s2_vld;
    logic [1:0]    s2_col;
    logic [1:0]    frame_cnt;
    logic [3:0]    frame_code;
    logic          frame_done;
    logic [2:0]    samp_lows;
    logic [2:0]    frame_sum;
    logic [1:0]    frame_cnt_next;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_next;
    logic [3:0]    cand;
    logic [3:0]    cand_next;
    logic          accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Column walk: the strobe moves on after SETTLE ticks, tagging a sample of the column just left
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_idx    <= 2'd0;
            col        <= 4'b1110;
            settle_cnt <= '0;
            s1_vld     <= 1'b0;
            s1_col     <= 2'd0;
        end else begin
            s1_vld <= 1'b0;
            if (enable) begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_cnt <= '0;
                    col_idx    <= col_idx + 2'd1;
                    col        <= {col[2:0], col[3]};
                    s1_vld     <= 1'b1;
                    s1_col     <= col_idx;
                end else begin
                    settle_cnt <= settle_cnt + SW'(1);
                end
            end
        end
    end

    // The rows of a column reach row_sync two clocks after they were on the pins,
    // so the sample tag rides a two-stage pipe to meet them.
    always_comb begin
        samp_lows = low_count(row_sync);
        if (s2_col == 2'd0) begin
            frame_sum = samp_lows;
        end else begin
            frame_sum = samp_lows + {1'b0, frame_cnt};
        end
        frame_cnt_next = (frame_sum >= 3'd2) ? 2'd2 : frame_sum[1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld     <= 1'b0;
            s2_col     <= 2'd0;
            frame_cnt  <= 2'd0;
            frame_code <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            s2_vld     <= s1_vld;
            s2_col     <= s1_col;
            frame_done <= s2_vld && (s2_col == 2'd3);
            if (s2_vld) begin
                frame_cnt <= frame_cnt_next;
                if ((samp_lows == 3'd1) && ((s2_col == 2'd0) || (frame_cnt == 2'd0))) begin
                    frame_code <= {s2_col, low_index(row_sync)};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // frame_cnt: 0 = no key, 1 = exactly one key (frame_code), 2 = ghosting / several keys
    always_comb begin
        state_next = state;
        dcnt_next  = dcnt;
        cand_next  = cand;
        accept     = 1'b0;
        if (frame_done) begin
            case (state)
                ST_IDLE: begin
                    if (frame_cnt == 2'd1) begin
                        cand_next = frame_code;
                        if (DEB_CNT == 1) begin
                            state_next = ST_HELD;
                            dcnt_next  = '0;
                            accept     = 1'b1;
                        end else begin
                            state_next = ST_PRESS_CHK;
                            dcnt_next  = DW'(1);
                        end
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_PRESS_CHK: begin
                    if ((frame_cnt == 2'd1) && (frame_code == cand)) begin
                        if (dcnt == DEB_LAST) begin
                            state_next = ST_HELD;
                            dcnt_next  = '0;
                            accept     = 1'b1;
                        end else begin
                            dcnt_next = dcnt + DW'(1);
                        end
                    end else begin
                        state_next = ST_IDLE;
                        dcnt_next  = '0;
                    end
                end
                ST_HELD: begin
                    if (frame_cnt == 2'd0) begin
                        if (DEB_CNT == 1) begin
                            state_next = ST_IDLE;
                            dcnt_next  = '0;
                        end else begin
                            state_next = ST_REL_CHK;
                            dcnt_next  = DW'(1);
                        end
                    end else begin
                        state_next = ST_HELD;
                    end
                end
                ST_REL_CHK: begin
                    if (frame_cnt == 2'd0) begin
                        if (dcnt == DEB_LAST) begin
                            state_next = ST_IDLE;
                            dcnt_next  = '0;
                        end else begin
                            dcnt_next = dcnt + DW'(1);
                        end
                    end else begin
                        state_next = ST_HELD;
                        dcnt_next  = '0;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    dcnt_next  = '0;
                end
            endcase
        end else begin
            state_next = state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt  <= '0;
            cand  <= 4'd0;
            key   <= 4'd0;
            valid <= 1'b0;
            held  <= 1'b0;
        end else begin
            dcnt  <= dcnt_next;
            cand  <= cand_next;
            valid <= accept;
            held  <= (state_next == ST_HELD) || (state_next == ST_REL_CHK);
            if (accept) begin
                key <= cand_next;
            end
        end
    end

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: a physical keypad model drives the rows from the strobed columns, and a
// frame-level debounce model predicts COL, KEY, VALID and HELD on every cycle.
module tb_key_scan;

    localparam int SETTLE  = 2;
    localparam int DEB_CNT = 4;
    localparam int FRAME   = 4 * SETTLE;
    localparam int OUT_LAG = 3;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        enable  = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        valid;
    logic        held;
    logic [15:0] pressed = 16'h0000;
    int          en_mode = 0;

    int checks   = 0;
    int failures = 0;

    key_scan #(.SETTLE(SETTLE), .DEB_CNT(DEB_CNT)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .row    (row),
        .col    (col),
        .key    (key),
        .valid  (valid),
        .held   (held)
    );

    always #5 clk = ~clk;

    // a row reads low when a pressed key connects it to a driven (low) column
    always_comb begin
        row = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col[c] && pressed[c*4+r]) row[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: frames of column samples, debounced as runs of identical frames
    int         ticks;
    logic [3:0] samp [4];
    int         run;
    int         rel;
    logic [3:0] cand;
    logic [3:0] m_key;
    logic       m_held;
    logic       m_valid;
    logic       dq_valid [OUT_LAG+1];
    logic [3:0] dq_key   [OUT_LAG+1];
    logic       dq_held  [OUT_LAG+1];
    bit         model_ok = 1'b0;
    int         lows;
    int         kind;
    logic [3:0] fcode;
    int         cur_col;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ticks = 0; run = 0; rel = 0; cand = 4'd0; m_key = 4'd0;
            m_held = 1'b0; m_valid = 1'b0; model_ok = 1'b1;
            for (int i = 0; i < 4; i++) samp[i] = 4'hF;
            for (int i = 0; i <= OUT_LAG; i++) begin
                dq_valid[i] = 1'b0; dq_key[i] = 4'd0; dq_held[i] = 1'b0;
            end
        end else begin
            m_valid = 1'b0;
            if (enable) begin
                cur_col = (ticks / SETTLE) % 4;
                if (ticks % SETTLE == SETTLE - 1) begin
                    samp[cur_col] = row;
                    if (cur_col == 3) begin
                        lows = 0; fcode = 4'd0;
                        for (int c = 0; c < 4; c++) begin
                            for (int r = 0; r < 4; r++) begin
                                if (!samp[c][r]) begin
                                    lows++;
                                    fcode = 4'(c * 4 + r);
                                end
                            end
                        end
                        kind = (lows >= 2) ? 2 : lows;
                        if (!m_held) begin
                            if (kind == 1 && run > 0 && fcode == cand) run++;
                            else if (kind == 1 && run == 0) begin cand = fcode; run = 1; end
                            else run = 0;
                            if (run == DEB_CNT) begin
                                m_held = 1'b1; m_key = cand; m_valid = 1'b1; run = 0;
                            end
                        end else begin
                            if (kind == 0) rel++;
                            else rel = 0;
                            if (rel == DEB_CNT) begin m_held = 1'b0; rel = 0; end
                        end
                    end
                end
                ticks++;
            end
            for (int i = OUT_LAG; i > 0; i--) begin
                dq_valid[i] = dq_valid[i-1]; dq_key[i] = dq_key[i-1]; dq_held[i] = dq_held[i-1];
            end
            dq_valid[0] = m_valid; dq_key[0] = m_key; dq_held[0] = m_held;
        end
    end

    logic [3:0] exp_col;
    always @(negedge clk) begin
        if (model_ok) begin
            exp_col = ~(4'b0001 << ((ticks / SETTLE) % 4));
            chk("col", col, exp_col);
            chk("valid", valid, dq_valid[OUT_LAG]);
            chk("key", key, dq_key[OUT_LAG]);
            chk("held", held, dq_held[OUT_LAG]);
        end
    end

    int cyc         = 0;
    int first_valid = -1;
    int valid_total = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst) first_valid = -1;
        else if (valid) begin
            valid_total++;
            if (first_valid < 0) first_valid = cyc;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            case (en_mode)
                0:       enable = 1'b1;
                1:       enable = ((cyc + 1) % 3 == 0);
                default: enable = ($urandom_range(0, 3) != 0);
            endcase
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    logic [3:0] col_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int v0;
    int hold_len;
    int k1;
    int k2;

    initial begin
        // reset values and the column walk with no key
        en_mode = 0; pressed = 16'h0000;
        do_reset();
        chk("t1_rst_col", col, 4'b1110);
        chk("t1_rst_key", key, 4'd0);
        chk("t1_rst_valid", valid, 1'b0);
        chk("t1_rst_held", held, 1'b0);
        for (int k = 0; k < 20; k++) begin
            chk("t1_col_seq", col, col_tab[(k / 2) % 4]);
            cycles(1);
        end

        // key row2/col1 held: single VALID after frame 4 plus pipeline
        pressed = 16'h0040;
        do_reset();
        v0 = valid_total;
        cycles(12 * FRAME);
        chk("t2_latency", first_valid, 35);
        chk("t2_key", key, 4'd6);
        chk("t2_model_key", m_key, 4'd6);
        chk("t2_held", held, 1'b1);
        chk("t2_valid_count", valid_total - v0, 1);

        // short release and re-press while held, then a full release
        v0 = valid_total;
        pressed = 16'h0000; cycles(2 * FRAME);
        pressed = 16'h0040; cycles(2 * FRAME);
        chk("t5_held_after_repress", held, 1'b1);
        pressed = 16'h0000; cycles(3 * FRAME);
        chk("t5_held_3_empty", held, 1'b1);
        cycles(2 * FRAME);
        chk("t5_held_released", held, 1'b0);
        chk("t5_valid_count", valid_total - v0, 0);

        // two keys in one frame are ghosting: ignored, KEY kept
        v0 = valid_total;
        pressed = 16'h0801;
        cycles(8 * FRAME);
        chk("t4_key_kept", key, 4'd6);
        chk("t4_held", held, 1'b0);
        chk("t4_valid_count", valid_total - v0, 0);

        // three frames of a key are not enough
        pressed = 16'h0040;
        do_reset();
        v0 = valid_total;
        cycles(3 * FRAME);
        pressed = 16'h0000;
        cycles(3 * FRAME);
        chk("t3_valid_count", valid_total - v0, 0);
        chk("t3_held", held, 1'b0);

        // reset in the middle of press debouncing, ENABLE every cycle then one in three
        for (int pass = 0; pass < 2; pass++) begin
            en_mode = pass;
            pressed = 16'h0040;
            do_reset();
            cycles((pass == 0) ? 3 * FRAME + 4 : 9 * FRAME + 10);
            chk("t6_model_run", run, 3);
            rst = 1'b1;
            #1;
            chk("t6_rst_col", col, 4'b1110);
            chk("t6_rst_valid", valid, 1'b0);
            chk("t6_rst_held", held, 1'b0);
            cycles(2);
            rst = 1'b0;
            v0 = valid_total;
            cycles((pass == 0) ? 12 * FRAME : 36 * FRAME);
            chk("t6_latency", first_valid, (pass == 0) ? 35 : 99);
            chk("t6_valid_count", valid_total - v0, 1);
            chk("t6_key", key, 4'd6);
        end

        // random keys, random ENABLE density, occasional reset
        en_mode = 2;
        pressed = 16'h0000;
        do_reset();
        for (int it = 0; it < 150; it++) begin
            k1 = $urandom_range(0, 15);
            k2 = $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                0:       pressed = 16'h0000;
                1, 2:    pressed = 16'h0001 << k1;
                default: pressed = (16'h0001 << k1) | (16'h0001 << k2);
            endcase
            hold_len = $urandom_range(1, 7) * FRAME + $urandom_range(0, FRAME - 1);
            cycles(hold_len);
            if ($urandom_range(0, 19) == 0) do_reset();
        end
        en_mode = 0;
        pressed = 16'h0000;
        cycles(10 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
